// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, controller states and
// the alignment rule used by the controller and the alignment helper.
package lsu_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Unknown size encodings are treated as word accesses throughout.
    function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] offset);
        logic w_mis;
        case (size)
            SZ_B, SZ_BU: w_mis = 1'b0;
            SZ_H, SZ_HU: w_mis = offset[0];
            default:     w_mis = |offset;
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: size + byte offset to byte enables and replicated store
// data, and lane extraction with sign/zero extension for load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    always_comb begin
        o_be      = 4'b1111;
        o_wdata   = i_wdata;
        // Misaligned accesses shift past lane 3; the shifted-out bytes read as zero.
        w_shifted = i_rdata >> {i_offset, 3'b000};
        o_rdata   = w_shifted;
        case (i_size)
            SZ_B: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            SZ_BU: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {24'd0, w_shifted[7:0]};
            end
            SZ_H: begin
                o_be    = 4'b0011 << i_offset;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            SZ_HU: begin
                o_be    = 4'b0011 << i_offset;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {16'd0, w_shifted[15:0]};
            end
            default: begin
                o_be    = 4'b1111 << i_offset;
                o_wdata = i_wdata;
                o_rdata = w_shifted;
            end
        endcase
    end

endmodule

// File: rtl/exu_lsu_ctrl.sv
// Load/store sequencer: one outstanding valid/ready bus access per execute request, with
// stall, timeout abort and extended load data. `LSU_MISALIGN_TRAP_EN` enables misalign traps.
module exu_lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_rreq,
    input  logic        i_mem_wreq,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [2:0]  i_mem_size,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        o_bus_valid,
    input  logic        i_bus_ready,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_next;

    logic [31:0] r_cnt;
    logic        r_we;
    logic [2:0]  r_size;
    logic [1:0]  r_off;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_be;
    logic [31:0] r_rdata;
    logic        r_misalign;
    logic        r_bus_err;

    logic        w_req;
    logic        w_trap;
    logic        w_timeout;
    logic [31:0] w_cnt_inc;
    logic [2:0]  w_al_size;
    logic [1:0]  w_al_off;
    logic [3:0]  w_al_be;
    logic [31:0] w_al_wdata;
    logic [31:0] w_al_rdata;

    assign w_req     = i_mem_rreq | i_mem_wreq;
    assign w_cnt_inc = r_cnt + 32'd1;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == TIMEOUT_CYCLES);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = lsu_misaligned(i_mem_size, i_mem_addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    // One aligner serves both directions: request fields in IDLE, the captured access later.
    assign w_al_size = (r_state == ST_IDLE) ? i_mem_size       : r_size;
    assign w_al_off  = (r_state == ST_IDLE) ? i_mem_addr[1:0] : r_off;

    lsu_align u_align (
        .i_size   (w_al_size),
        .i_offset (w_al_off),
        .i_wdata  (i_mem_wdata),
        .i_rdata  (i_bus_rdata),
        .o_be     (w_al_be),
        .o_wdata  (w_al_wdata),
        .o_rdata  (w_al_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_stall      = 1'b0;
        o_bus_valid  = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    o_stall      = 1'b1;
                    w_state_next = w_trap ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                o_stall     = 1'b1;
                o_bus_valid = 1'b1;
                if (w_timeout) begin
                    w_state_next = ST_DONE;
                end else if (i_bus_ready) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                o_stall = 1'b1;
                if (i_bus_rvalid || w_timeout) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_size      <= '0;
            r_off       <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
            r_rdata     <= '0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        // A simultaneous load and store request resolves to the store.
                        r_we        <= i_mem_wreq;
                        r_size      <= i_mem_size;
                        r_off       <= i_mem_addr[1:0];
                        r_bus_addr  <= {i_mem_addr[31:2], 2'b00};
                        r_bus_wdata <= w_al_wdata;
                        r_bus_be    <= w_al_be;
                        r_cnt       <= '0;
                        r_rdata     <= '0;
                        r_misalign  <= w_trap;
                        r_bus_err   <= 1'b0;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if ((r_state == ST_WAIT) && i_bus_rvalid) begin
                        r_rdata <= r_we ? '0 : w_al_rdata;
                    end else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rdata     = r_rdata;
    assign o_misalign  = r_misalign;
    assign o_bus_err   = r_bus_err;
    assign o_bus_we    = r_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_bus_be    = r_bus_be;

endmodule

// File: tb/tb_exu_lsu_ctrl.sv
// Self-checking bench for exu_lsu_ctrl: directed and random accesses against a byte-level
// model, plus timeout and mid-transaction reset on a short-timeout instance.
module tb_exu_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_mem_rreq, i_mem_wreq;
    logic [31:0] i_mem_addr, i_mem_wdata;
    logic [2:0]  i_mem_size;
    logic        i_bus_ready, i_bus_rvalid;
    logic [31:0] i_bus_rdata;

    logic        o_stall, o_done, o_misalign, o_bus_err, o_bus_valid, o_bus_we;
    logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;

    logic        t_stall, t_done, t_misalign, t_bus_err, t_bus_valid, t_bus_we;
    logic [31:0] t_rdata, t_bus_addr, t_bus_wdata;
    logic [3:0]  t_bus_be;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    exu_lsu_ctrl dut (
        .clk(clk), .rst(rst), .i_mem_rreq(i_mem_rreq), .i_mem_wreq(i_mem_wreq),
        .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata), .i_mem_size(i_mem_size),
        .o_stall(o_stall), .o_done(o_done), .o_rdata(o_rdata), .o_misalign(o_misalign),
        .o_bus_err(o_bus_err), .o_bus_valid(o_bus_valid), .i_bus_ready(i_bus_ready),
        .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
        .o_bus_be(o_bus_be), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata)
    );

    exu_lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst), .i_mem_rreq(i_mem_rreq), .i_mem_wreq(i_mem_wreq),
        .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata), .i_mem_size(i_mem_size),
        .o_stall(t_stall), .o_done(t_done), .o_rdata(t_rdata), .o_misalign(t_misalign),
        .o_bus_err(t_bus_err), .o_bus_valid(t_bus_valid), .i_bus_ready(i_bus_ready),
        .o_bus_we(t_bus_we), .o_bus_addr(t_bus_addr), .o_bus_wdata(t_bus_wdata),
        .o_bus_be(t_bus_be), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata)
    );

    // Reference model: accesses as lists of bytes.
    function automatic int m_nbytes(input logic [2:0] sz);
        if (sz == 3'b000 || sz == 3'b100) return 1;
        if (sz == 3'b001 || sz == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [1:0] off);
        logic [3:0] b = '0;
        for (int k = 0; k < m_nbytes(sz); k++) if (int'(off) + k < 4) b[int'(off) + k] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int n = m_nbytes(sz);
        for (int l = 0; l < 4; l++) r[8*l +: 8] = wd[8*(l % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] sz, input logic [1:0] off,
                                            input logic [31:0] rd);
        logic [63:0] v = '0;
        int n = m_nbytes(sz);
        for (int k = 0; k < n; k++)
            if (int'(off) + k < 4) v = v + (64'(rd[8*(int'(off) + k) +: 8]) << (8*k));
        if ((sz == 3'b000 || sz == 3'b001) && v[8*n-1]) v = v - (64'd1 << (8*n));
        return v[31:0];
    endfunction

    function automatic bit m_mis(input logic [2:0] sz, input logic [1:0] off);
        int n = m_nbytes(sz);
        return (n == 2 && off[0]) || (n == 4 && off != 2'b00);
    endfunction

    task automatic txn(input bit we, input bit both, input logic [31:0] addr,
                       input logic [2:0] sz, input logic [31:0] wd, input logic [31:0] rd,
                       input int rdly, input int vdly,
                       output logic [31:0] obs_rd, output logic [3:0] obs_be);
        bit          trap, seen, in_wait;
        int          lat, nreq, nwait, exp_lat;
        logic [31:0] exp_rd;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = m_mis(sz, addr[1:0]);
`else
        trap = 1'b0;
`endif
        exp_rd  = (we || trap) ? 32'd0 : m_rdata(sz, addr[1:0], rd);
        exp_lat = trap ? 1 : rdly + vdly + 3;
        obs_rd  = '0;
        obs_be  = '0;
        @(negedge clk);
        i_mem_rreq = !we || both; i_mem_wreq = we;
        i_mem_addr = addr; i_mem_size = sz; i_mem_wdata = wd;
        #1;
        n_cmp++;
        if (o_stall !== 1'b1) begin
            n_fail++; $display("FAIL stall_on_req got=%0b exp=1", o_stall);
        end
        lat = 0; nreq = 0; nwait = 0; in_wait = 0; seen = 0;
        while (!seen && lat < 64) begin
            @(negedge clk);
            lat++;
            i_bus_ready = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = $urandom;
            if (o_done === 1'b1) begin
                seen = 1; obs_rd = o_rdata;
                i_mem_rreq = 1'b0; i_mem_wreq = 1'b0;
                n_cmp++;
                if (lat != exp_lat) begin
                    n_fail++; $display("FAIL done_latency got=%0d exp=%0d", lat, exp_lat);
                end
                n_cmp++;
                if (o_rdata !== exp_rd) begin
                    n_fail++; $display("FAIL rdata addr=%h sz=%0d got=%h exp=%h",
                                       addr, sz, o_rdata, exp_rd);
                end
                n_cmp++;
                if ({o_misalign, o_bus_err, o_stall} !== {trap, 1'b0, 1'b0}) begin
                    n_fail++; $display("FAIL done_flags got=%b exp=%b",
                                       {o_misalign, o_bus_err, o_stall}, {trap, 2'b00});
                end
            end else if (o_bus_valid === 1'b1) begin
                if (trap) begin
                    n_cmp++; n_fail++; $display("FAIL trap_bus_valid got=1 exp=0");
                end
                if (nreq == 0) obs_be = o_bus_be;
                n_cmp++;
                if ({o_bus_addr, o_bus_be, o_bus_wdata, o_bus_we, o_stall} !==
                    {addr[31:2], 2'b00, m_be(sz, addr[1:0]), m_wdata(sz, wd), we, 1'b1}) begin
                    n_fail++;
                    $display("FAIL bus_fields got=%h/%b/%h/%b exp=%h/%b/%h/%b", o_bus_addr,
                             o_bus_be, o_bus_wdata, o_bus_we, {addr[31:2], 2'b00},
                             m_be(sz, addr[1:0]), m_wdata(sz, wd), we);
                end
                // Junk response alongside the request phase must be ignored.
                i_bus_rvalid = 1'b1;
                if (nreq == rdly) begin
                    i_bus_ready = 1'b1; in_wait = 1;
                end
                nreq++;
            end else if (in_wait) begin
                n_cmp++;
                if (o_stall !== 1'b1) begin
                    n_fail++; $display("FAIL stall_wait got=%0b exp=1", o_stall);
                end
                if (nwait == vdly) begin
                    i_bus_rvalid = 1'b1; i_bus_rdata = rd;
                end
                nwait++;
            end else begin
                n_cmp++; n_fail++;
                $display("FAIL no_progress lat=%0d got=idle exp=bus_or_done", lat);
                seen = 1;
                i_mem_rreq = 1'b0; i_mem_wreq = 1'b0;
            end
        end
        if (!seen) begin
            n_cmp++; n_fail++; $display("FAIL done_timeout got=none exp=o_done");
            i_mem_rreq = 1'b0; i_mem_wreq = 1'b0;
        end
        i_bus_ready = 1'b0; i_bus_rvalid = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({o_stall, o_done, o_misalign, o_bus_err, o_bus_valid, o_bus_we, o_rdata,
             o_bus_addr, o_bus_wdata, o_bus_be} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got=%b/%h/%h/%h/%b exp=0",
                               {o_stall, o_done, o_misalign, o_bus_err, o_bus_valid, o_bus_we},
                               o_rdata, o_bus_addr, o_bus_wdata, o_bus_be);
        end
        n_cmp++;
        if ({t_stall, t_done, t_bus_valid, t_bus_err, t_rdata, t_bus_be} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_to got=%b exp=0", t_bus_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] rd;
        logic [3:0]  be;
        txn(0, 0, 32'h100, 3'b010, 32'h0, 32'hDEADBEEF, 0, 0, rd, be);
        n_cmp++;
        if ({rd, be} !== {32'hDEADBEEF, 4'b1111}) begin
            n_fail++; $display("FAIL lw_100 got=%h/%b exp=deadbeef/1111", rd, be);
        end
        txn(0, 0, 32'h203, 3'b000, 32'h0, 32'h80FFFF7F, 0, 0, rd, be);
        n_cmp++;
        if ({rd, be} !== {32'hFFFFFF80, 4'b1000}) begin
            n_fail++; $display("FAIL lb_203 got=%h/%b exp=ffffff80/1000", rd, be);
        end
        txn(0, 0, 32'h203, 3'b100, 32'h0, 32'h80FFFF7F, 1, 1, rd, be);
        n_cmp++;
        if (rd !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu_203 got=%h exp=00000080", rd);
        end
        txn(1, 0, 32'h302, 3'b001, 32'h1234ABCD, 32'h0, 3, 0, rd, be);
        n_cmp++;
        if ({rd, be} !== {32'h0, 4'b1100}) begin
            n_fail++; $display("FAIL sh_302 got=%h/%b exp=0/1100", rd, be);
        end
        txn(0, 0, 32'h101, 3'b010, 32'h0, 32'h11223344, 0, 0, rd, be);
`ifdef LSU_MISALIGN_TRAP_EN
        n_cmp++;
        if ({rd, be} !== {32'h0, 4'b0000}) begin
            n_fail++; $display("FAIL lw_101_trap got=%h/%b exp=0/0000", rd, be);
        end
`else
        n_cmp++;
        if ({rd, be} !== {32'h00112233, 4'b1110}) begin
            n_fail++; $display("FAIL lw_101 got=%h/%b exp=00112233/1110", rd, be);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [2:0]  sizes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [31:0] rd;
        logic [3:0]  be;
        for (int i = 0; i < 40; i++) begin
            txn(1'($urandom), 1'($urandom), $urandom, sizes[$urandom_range(0, 4)], $urandom,
                $urandom, $urandom_range(0, 2), $urandom_range(0, 2), rd, be);
        end
    endtask

    task automatic test_timeout(input bit give_ready);
        int lat, nvalid;
        bit seen;
        pulse_rst();
        @(negedge clk);
        i_mem_rreq = 1'b1; i_mem_wreq = 1'b0; i_mem_addr = 32'h400; i_mem_size = 3'b010;
        lat = 0; nvalid = 0; seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            i_bus_ready = give_ready; i_bus_rvalid = 1'b0;
            if (t_done === 1'b1) begin
                seen = 1; i_mem_rreq = 1'b0;
                n_cmp++;
                if ({t_bus_err, t_rdata, t_stall} !== {1'b1, 32'h0, 1'b0}) begin
                    n_fail++; $display("FAIL timeout_flags got=%b/%h/%b exp=1/0/0",
                                       t_bus_err, t_rdata, t_stall);
                end
                n_cmp++;
                if (lat != 5) begin
                    n_fail++; $display("FAIL timeout_latency got=%0d exp=5", lat);
                end
            end else if (t_bus_valid === 1'b1) begin
                nvalid++;
            end
        end
        i_mem_rreq = 1'b0; i_bus_ready = 1'b0;
        n_cmp++;
        if (!seen || nvalid != (give_ready ? 1 : 4)) begin
            n_fail++; $display("FAIL timeout_valid_cycles got=%0d/%0b exp=%0d/1",
                               nvalid, seen, give_ready ? 1 : 4);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_bus_rvalid = 1'b1; i_bus_rdata = $urandom;
            n_cmp++;
            if ({t_done, t_bus_valid} !== 2'b00) begin
                n_fail++; $display("FAIL late_rvalid got=%b exp=00", {t_done, t_bus_valid});
            end
        end
        i_bus_rvalid = 1'b0;
        pulse_rst();
    endtask

    task automatic test_rst_mid();
        logic [31:0] rd;
        logic [3:0]  be;
        @(negedge clk);
        i_mem_rreq = 1'b1; i_mem_wreq = 1'b0; i_mem_addr = 32'h500; i_mem_size = 3'b010;
        @(negedge clk);
        i_bus_ready = 1'b1;
        @(negedge clk);
        i_bus_ready = 1'b0; i_mem_rreq = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({o_stall, o_done, o_misalign, o_bus_err, o_bus_valid, o_bus_we, o_rdata,
             o_bus_addr, o_bus_wdata, o_bus_be} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs got=%b/%h/%h exp=0",
                               {o_stall, o_done, o_bus_valid, o_bus_we}, o_bus_addr, o_bus_be);
        end
        rst = 1'b0;
        txn(0, 0, 32'h504, 3'b010, 32'h0, 32'hCAFEF00D, 0, 1, rd, be);
        n_cmp++;
        if (rd !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL lw_after_rst got=%h exp=cafef00d", rd);
        end
    endtask

    initial begin
        i_mem_rreq = 1'b0; i_mem_wreq = 1'b0; i_mem_addr = '0; i_mem_wdata = '0;
        i_mem_size = '0; i_bus_ready = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_timeout(1'b1);
        test_timeout(1'b0);
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
